// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared state encodings and partial-product shift codes for mult_arb
package mult_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [1:0] SHIFT_0 = 2'b00;
  localparam logic [1:0] SHIFT_4 = 2'b01;
  localparam logic [1:0] SHIFT_8 = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker; on contention the requester not granted last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       id
);

  always_comb begin
    valid = |req;
    case (req)
      2'b01:   id = 1'b0;
      2'b10:   id = 1'b1;
      2'b11:   id = ~last;
      default: id = 1'b0;
    endcase
  end

endmodule

// File: rtl/mult_arb.sv
// rtl/mult_arb.sv - arbitrates two 8x8 multiply requests onto a shared 4x4 datapath
// and sequences its four nibble partial products.
module mult_arb
  import mult_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] dp_a,
  output logic [7:0] dp_b,
  output logic       input_sela,
  output logic       input_selb,
  output logic [1:0] shift_sel,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       done,
  output logic       done_id,
  output logic       busy
);

  state_t state, state_nx;
  logic   last_q;
  logic   owner_q;
  logic   arb_valid;
  logic   arb_id;
  logic   take;

  rr_arb2 u_rr_arb2 (
    .req   ({req1, req0}),
    .last  (last_q),
    .valid (arb_valid),
    .id    (arb_id)
  );

  // Requests are only looked at between operations.
  assign take = arb_valid && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      dp_a    <= 8'h00;
      dp_b    <= 8'h00;
    end else begin
      state <= state_nx;
      if (take) begin
        last_q  <= arb_id;
        owner_q <= arb_id;
        dp_a    <= arb_id ? a1 : a0;
        dp_b    <= arb_id ? b1 : b0;
      end
    end
  end

  // Outputs decode from registered state only, so req* never reaches an output combinationally.
  always_comb begin
    state_nx   = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    input_sela = 1'b0;
    input_selb = 1'b0;
    shift_sel  = SHIFT_0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    done       = 1'b0;
    done_id    = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (take) state_nx = P0;
      end
      P0: begin
        gnt0     = ~owner_q;
        gnt1     = owner_q;
        acc_en   = 1'b1;
        acc_clr  = 1'b1;
        state_nx = P1;
      end
      P1: begin
        input_selb = 1'b1;
        shift_sel  = SHIFT_4;
        acc_en     = 1'b1;
        state_nx   = P2;
      end
      P2: begin
        input_sela = 1'b1;
        shift_sel  = SHIFT_4;
        acc_en     = 1'b1;
        state_nx   = P3;
      end
      P3: begin
        input_sela = 1'b1;
        input_selb = 1'b1;
        shift_sel  = SHIFT_8;
        acc_en     = 1'b1;
        state_nx   = DONE;
      end
      DONE: begin
        done     = 1'b1;
        done_id  = owner_q;
        state_nx = take ? P0 : IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_arb.sv
// tb/tb_mult_arb.sv - self-checking bench for mult_arb with a behavioural 4x4 datapath
// and a round-robin/product reference model.
module tb_mult_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       gnt0, gnt1, input_sela, input_selb, acc_clr, acc_en, done, done_id, busy;
  logic [7:0] dp_a, dp_b;
  logic [1:0] shift_sel;
  logic [15:0] acc;

  int n_tests = 0;
  int n_fail  = 0;
  logic model_last;

  typedef struct {
    logic        r0, r1;
    logic [7:0]  a0, b0, a1, b1;
    logic        id;
    logic [15:0] prod;
  } vec_t;
  vec_t tbl[7];

  mult_arb dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .dp_a(dp_a), .dp_b(dp_b),
    .input_sela(input_sela), .input_selb(input_selb), .shift_sel(shift_sel),
    .acc_clr(acc_clr), .acc_en(acc_en), .done(done), .done_id(done_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // External shared datapath: 4x4 nibble multiply, shift, accumulate.
  always_ff @(posedge clk) begin
    logic [15:0] pp;
    pp = 16'(({4'h0, (input_sela ? dp_a[7:4] : dp_a[3:0])} * {4'h0, (input_selb ? dp_b[7:4] : dp_b[3:0])}));
    pp = pp << (4 * shift_sel);
    if (acc_en) acc <= acc_clr ? pp : acc + pp;
  end

  function automatic logic [9:0] outv();
    return {gnt0, gnt1, input_sela, input_selb, shift_sel, acc_clr, acc_en, done, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full operation from IDLE: request edge, P0..P3, DONE, back to IDLE.
  task automatic run_op(input string name, input logic r0, input logic r1,
                        input logic [7:0] ia0, input logic [7:0] ib0,
                        input logic [7:0] ia1, input logic [7:0] ib1,
                        input logic id, input logic [15:0] prod);
    logic [3:0] sa, sb;
    logic [1:0] shv[4];
    logic [15:0] ops;
    sa = 4'b1100;
    sb = 4'b1010;
    shv = '{2'd0, 2'd1, 2'd1, 2'd2};
    ops = id ? {ia1, ib1} : {ia0, ib0};
    req0 = r0; req1 = r1; a0 = ia0; b0 = ib0; a1 = ia1; b1 = ib1;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    for (int ph = 0; ph < 4; ph++) begin
      chk({name, "_phase"}, 32'(outv()),
          32'({ph == 0 && !id, ph == 0 && id, sa[ph], sb[ph], shv[ph], ph == 0, 1'b1, 1'b0, 1'b1}));
      chk({name, "_dp"}, 32'({dp_a, dp_b}), 32'(ops));
      if (ph == 1) begin a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1; end
      tick();
    end
    chk({name, "_done"}, 32'({outv(), done_id}), 32'({10'b00_0000_0011, id}));
    chk({name, "_prod"}, 32'(acc), 32'(prod));
    chk({name, "_dp_done"}, 32'({dp_a, dp_b}), 32'(ops));
    tick();
    chk({name, "_idle"}, 32'({outv(), done_id}), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 16'hFE01};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h12, 8'h34, 1'b1, 16'h03A8};
    tbl[2] = '{1'b1, 1'b1, 8'h10, 8'h10, 8'h55, 8'h66, 1'b0, 16'h0100};
    tbl[3] = '{1'b1, 1'b1, 8'h77, 8'h88, 8'h0F, 8'hF0, 1'b1, 16'h0E10};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h02, 1'b1, 16'h0100};
    tbl[5] = '{1'b1, 1'b1, 8'h00, 8'hAB, 8'h99, 8'h99, 1'b0, 16'h0000};
    tbl[6] = '{1'b1, 1'b0, 8'h7F, 8'h81, 8'h00, 8'h00, 1'b0, 16'h3FFF};

    tick();
    chk("reset_outputs", 32'({outv(), done_id}), 32'd0);
    chk("reset_dp", 32'({dp_a, dp_b}), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_hold", 32'(outv()), 32'd0);

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].b0,
             tbl[i].a1, tbl[i].b1, tbl[i].id, tbl[i].prod);

    // Simultaneous first requests: req0 first, req1 granted straight out of DONE.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; a0 = 8'hFF; b0 = 8'hFF; a1 = 8'h12; b1 = 8'h34;
    tick();
    chk("both_first_gnt", 32'({gnt0, gnt1}), 32'b10);
    req0 = 1'b0;
    repeat (4) tick();
    chk("both_done0", 32'({done, done_id}), 32'b10);
    chk("both_prod0", 32'(acc), 32'hFE01);
    tick();
    chk("both_second_gnt", 32'({gnt0, gnt1, busy}), 32'b011);
    req1 = 1'b0;
    repeat (4) tick();
    chk("both_done1", 32'({done, done_id}), 32'b11);
    chk("both_prod1", 32'(acc), 32'h03A8);
    tick();
    chk("both_idle", 32'(busy), 32'd0);

    // Both requests held: grants alternate with no idle gap.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("alt_c%0d", c), 32'({gnt0, gnt1, busy}),
          32'({c % 5 == 0 && (c / 5) % 2 == 0, c % 5 == 0 && (c / 5) % 2 == 1, 1'b1}));
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    begin
      int n = 0;
      while (busy && n < 8) begin tick(); n++; end
      chk("alt_drain", 32'(busy), 32'd0);
    end

    // Asynchronous reset in P2 after a req0 grant.
    req0 = 1'b1; a0 = 8'h33; b0 = 8'h44;
    tick();
    req0 = 1'b0;
    tick(); tick();
    chk("pre_rst_p2", 32'({input_sela, input_selb, busy}), 32'b101);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_out", 32'({outv(), done_id}), 32'd0);
    chk("rst_async_dp", 32'({dp_a, dp_b}), 32'd0);
    tick(); tick();
    rst = 1'b1;
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 8; c++) begin tick(); seen |= done | busy; end
      chk("no_done_after_rst", 32'(seen), 32'd0);
    end
    run_op("post_rst", 1'b1, 1'b1, 8'h21, 8'h43, 8'h5A, 8'hA5, 1'b0, 16'h08A3);

    // Randomized traffic against the reference model.
    do_reset();
    model_last = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [1:0] r;
      logic [7:0] ra0, rb0, ra1, rb1;
      logic w;
      r = 2'($urandom_range(0, 3));
      ra0 = 8'($urandom); rb0 = 8'($urandom); ra1 = 8'($urandom); rb1 = 8'($urandom);
      if (r == 2'b00) begin
        tick();
        chk("rnd_idle", 32'(outv()), 32'd0);
      end else begin
        w = (r == 2'b11) ? ~model_last : r[1];
        model_last = w;
        run_op($sformatf("rnd%0d", t), r[0], r[1], ra0, rb0, ra1, rb1, w,
               w ? 16'(ra1) * 16'(rb1) : 16'(ra0) * 16'(rb0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (gnt0 && gnt1) begin
      n_tests++;
      n_fail++;
      $display("FAIL dual_gnt: got gnt0=%b gnt1=%b expected at most one", gnt0, gnt1);
    end
  end

endmodule
